// File: rtl/arb4way16.sv
// Round-robin arbiter for four sources sharing one WIDTH-bit path.
// Grant, selected index and the steered data word are all registered.
module arb4way16 #(
    parameter int WIDTH    = 16,
    parameter int MAX_HOLD = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    output logic [3:0]       grant,
    output logic [1:0]       sel,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             busy
);

    typedef enum logic {IDLE, GRANT} state_t;

    // MAX_HOLD=0 disables preemption; the counter then just saturates at 255.
    localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);
    localparam logic [7:0] HOLD_SAT = (MAX_HOLD == 0) ? 8'd255 : 8'(MAX_HOLD);

    state_t           state, state_nxt;
    logic [1:0]       ptr, ptr_nxt;
    logic [1:0]       sel_nxt;
    logic [3:0]       grant_nxt;
    logic [7:0]       hold_cnt, hold_nxt;
    logic [WIDTH-1:0] out_nxt;
    logic             valid_nxt;
    logic [WIDTH-1:0] sel_data;
    logic [3:0]       others;
    logic [2:0]       pick_idle;
    logic [2:0]       pick_sw;

    // Returns {found, index}: first set bit of r scanning start, start+1, ... mod 4.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] start);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            idx = start + 2'(i);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    assign others    = req & ~grant;
    assign pick_idle = rr_pick(req, ptr);
    assign pick_sw   = rr_pick(others, sel + 2'd1);
    assign busy      = (state == GRANT);

    always_comb begin
        sel_data = a;
        case (sel)
            2'd0: sel_data = a;
            2'd1: sel_data = b;
            2'd2: sel_data = c;
            2'd3: sel_data = d;
        endcase
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        sel_nxt   = sel;
        ptr_nxt   = ptr;
        hold_nxt  = hold_cnt;
        out_nxt   = out;
        valid_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (pick_idle[2]) begin
                    state_nxt = GRANT;
                    grant_nxt = 4'b0001 << pick_idle[1:0];
                    sel_nxt   = pick_idle[1:0];
                    hold_nxt  = 8'd1;
                end
            end
            GRANT: begin
                if (req[sel]) begin
                    out_nxt   = sel_data;
                    valid_nxt = 1'b1;
                end
                if (!req[sel]) begin
                    // Release: hand over directly if anyone else is waiting.
                    ptr_nxt  = sel + 2'd1;
                    hold_nxt = 8'd1;
                    if (pick_sw[2]) begin
                        grant_nxt = 4'b0001 << pick_sw[1:0];
                        sel_nxt   = pick_sw[1:0];
                    end else begin
                        grant_nxt = 4'b0000;
                        state_nxt = IDLE;
                    end
                end else if (MAX_HOLD != 0 && hold_cnt == HOLD_LIM && others != 4'b0000) begin
                    ptr_nxt   = sel + 2'd1;
                    hold_nxt  = 8'd1;
                    grant_nxt = 4'b0001 << pick_sw[1:0];
                    sel_nxt   = pick_sw[1:0];
                end else if (hold_cnt != HOLD_SAT) begin
                    hold_nxt = hold_cnt + 8'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            grant     <= 4'b0000;
            sel       <= 2'd0;
            ptr       <= 2'd0;
            hold_cnt  <= 8'd0;
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            grant     <= grant_nxt;
            sel       <= sel_nxt;
            ptr       <= ptr_nxt;
            hold_cnt  <= hold_nxt;
            out       <= out_nxt;
            out_valid <= valid_nxt;
        end
    end

endmodule

// File: tb/tb_arb4way16.sv
// Bench for arb4way16: directed vector table, hand sequences and randomized
// traffic checked against a rule-level round-robin model (MAX_HOLD=4 and 0).
module tb_arb4way16;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [15:0] a, b, c, d;
    logic [3:0]  grant0, grant1;
    logic [1:0]  sel0, sel1;
    logic [15:0] out0, out1;
    logic        ov0, ov1, busy0, busy1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    arb4way16 #(.WIDTH(16), .MAX_HOLD(4)) u0 (
        .clk(clk), .reset(reset), .req(req), .a(a), .b(b), .c(c), .d(d),
        .grant(grant0), .sel(sel0), .out(out0), .out_valid(ov0), .busy(busy0)
    );

    arb4way16 #(.WIDTH(16), .MAX_HOLD(0)) u1 (
        .clk(clk), .reset(reset), .req(req), .a(a), .b(b), .c(c), .d(d),
        .grant(grant1), .sel(sel1), .out(out1), .out_valid(ov1), .busy(busy1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: grantee index (-1 = idle), priority pointer, hold count.
    int          mg[2], mptr[2], mhold[2], msel[2];
    logic [15:0] mout[2];
    bit          mv[2];

    function automatic int mh(input int k);
        return (k == 0) ? 4 : 0;
    endfunction

    function automatic int first_from(input logic [3:0] r, input int start);
        for (int i = 0; i < 4; i++)
            if (r[(start + i) % 4]) return (start + i) % 4;
        return -1;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            mg[k] = -1; mptr[k] = 0; mhold[k] = 0; msel[k] = 0;
            mout[k] = 16'h0; mv[k] = 1'b0;
        end
    endtask

    task automatic model_edge();
        logic [15:0] din[4];
        logic [3:0]  others;
        int g, w, lim;
        din = '{a, b, c, d};
        for (int k = 0; k < 2; k++) begin
            g = mg[k];
            lim = (mh(k) == 0) ? 255 : mh(k);
            if (g < 0) begin
                mv[k] = 1'b0;
                w = first_from(req, mptr[k]);
                if (w >= 0) begin
                    mg[k] = w; msel[k] = w; mhold[k] = 1;
                end
            end else begin
                mv[k] = req[g];
                if (req[g]) mout[k] = din[g];
                others = req;
                others[g] = 1'b0;
                if (!req[g] || (mh(k) != 0 && mhold[k] == mh(k) && others != 4'b0)) begin
                    mptr[k] = (g + 1) % 4;
                    mg[k] = first_from(others, (g + 1) % 4);
                    mhold[k] = 1;
                    if (mg[k] >= 0) msel[k] = mg[k];
                end else if (mhold[k] < lim) begin
                    mhold[k]++;
                end
            end
        end
    endtask

    task automatic check_model();
        logic [3:0] eg;
        for (int k = 0; k < 2; k++) begin
            eg = (mg[k] < 0) ? 4'b0000 : 4'(1 << mg[k]);
            chk($sformatf("model_grant_mh%0d", mh(k)), 32'(k == 0 ? grant0 : grant1), 32'(eg));
            chk($sformatf("model_sel_mh%0d", mh(k)), 32'(k == 0 ? sel0 : sel1), 32'(msel[k]));
            chk($sformatf("model_out_mh%0d", mh(k)), 32'(k == 0 ? out0 : out1), 32'(mout[k]));
            chk($sformatf("model_valid_mh%0d", mh(k)), 32'(k == 0 ? ov0 : ov1), 32'(mv[k]));
            chk($sformatf("model_busy_mh%0d", mh(k)), 32'(k == 0 ? busy0 : busy1), 32'(eg != 4'b0));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset) model_edge();
        #1;
        check_model();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req = 4'b0000;
        model_clear();
        #2;
        chk("rst_grant", 32'(grant0), 32'h0);
        chk("rst_sel", 32'(sel0), 32'h0);
        chk("rst_out", 32'(out0), 32'h0);
        chk("rst_valid", 32'(ov0), 32'h0);
        chk("rst_busy", 32'(busy0), 32'h0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct {
        bit          rst;
        logic [3:0]  rq;
        logic [3:0]  g;
        logic [1:0]  s;
        bit          v;
        logic [15:0] o;
    } vec_t;

    vec_t tbl[23];

    initial begin
        reset = 1'b1;
        req = 4'b0000;
        a = 16'h1111; b = 16'h2222; c = 16'h3333; d = 16'h4444;
        model_clear();

        tbl = '{
            // single requester, source 2
            '{1'b1, 4'b0100, 4'b0100, 2'd2, 1'b0, 16'h0000},
            '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, 16'h3333},
            '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, 16'h3333},
            '{1'b0, 4'b0100, 4'b0100, 2'd2, 1'b1, 16'h3333},
            '{1'b0, 4'b0000, 4'b0000, 2'd2, 1'b0, 16'h3333},
            '{1'b0, 4'b0000, 4'b0000, 2'd2, 1'b0, 16'h3333},
            // all four requesting, rotation every MAX_HOLD=4 grants
            '{1'b1, 4'b1111, 4'b0001, 2'd0, 1'b0, 16'h0000},
            '{1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1, 16'h1111},
            '{1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1, 16'h1111},
            '{1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1, 16'h1111},
            '{1'b0, 4'b1111, 4'b0010, 2'd1, 1'b1, 16'h1111},
            '{1'b0, 4'b1111, 4'b0010, 2'd1, 1'b1, 16'h2222},
            '{1'b0, 4'b1111, 4'b0010, 2'd1, 1'b1, 16'h2222},
            '{1'b0, 4'b1111, 4'b0010, 2'd1, 1'b1, 16'h2222},
            '{1'b0, 4'b1111, 4'b0100, 2'd2, 1'b1, 16'h2222},
            '{1'b0, 4'b1111, 4'b0100, 2'd2, 1'b1, 16'h3333},
            '{1'b0, 4'b1111, 4'b0100, 2'd2, 1'b1, 16'h3333},
            '{1'b0, 4'b1111, 4'b0100, 2'd2, 1'b1, 16'h3333},
            '{1'b0, 4'b1111, 4'b1000, 2'd3, 1'b1, 16'h3333},
            '{1'b0, 4'b1111, 4'b1000, 2'd3, 1'b1, 16'h4444},
            '{1'b0, 4'b1111, 4'b1000, 2'd3, 1'b1, 16'h4444},
            '{1'b0, 4'b1111, 4'b1000, 2'd3, 1'b1, 16'h4444},
            '{1'b0, 4'b1111, 4'b0001, 2'd0, 1'b1, 16'h4444}
        };

        for (int i = 0; i < 23; i++) begin
            if (tbl[i].rst) do_reset();
            req = tbl[i].rq;
            tick();
            chk($sformatf("vec%0d_grant", i), 32'(grant0), 32'(tbl[i].g));
            chk($sformatf("vec%0d_sel", i), 32'(sel0), 32'(tbl[i].s));
            chk($sformatf("vec%0d_valid", i), 32'(ov0), 32'(tbl[i].v));
            chk($sformatf("vec%0d_out", i), 32'(out0), 32'(tbl[i].o));
        end

        // Reset asserted while source 1 is granted clears outputs at once.
        do_reset();
        req = 4'b0010;
        tick();
        tick();
        chk("midrst_pre_grant", 32'(grant0), 32'h2);
        chk("midrst_pre_out", 32'(out0), 32'h2222);
        #2;
        reset = 1'b1;
        model_clear();
        #1;
        chk("midrst_grant", 32'(grant0), 32'h0);
        chk("midrst_out", 32'(out0), 32'h0);
        chk("midrst_valid", 32'(ov0), 32'h0);
        chk("midrst_sel", 32'(sel0), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        chk("midrst_regrant", 32'(grant0), 32'h2);

        // Grantee 0 releases while 1 and 3 wait: direct switch to source 1.
        do_reset();
        req = 4'b1011;
        tick();
        chk("release_first", 32'(grant0), 32'h1);
        req = 4'b1010;
        tick();
        chk("release_switch", 32'(grant0), 32'h2);
        tick();
        chk("release_out", 32'(out0), 32'h2222);
        chk("release_valid", 32'(ov0), 32'h1);

        // Lone requester is never preempted by its own hold limit.
        do_reset();
        req = 4'b1000;
        tick();
        chk("sat_first", 32'(grant0), 32'h8);
        for (int i = 0; i < 9; i++) begin
            tick();
            chk($sformatf("sat%0d_grant", i), 32'(grant0), 32'h8);
            chk($sformatf("sat%0d_out", i), 32'(out0), 32'h4444);
            chk($sformatf("sat%0d_valid", i), 32'(ov0), 32'h1);
        end

        // MAX_HOLD=0: source 0 keeps the grant until it lets go.
        do_reset();
        req = 4'b0011;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk($sformatf("nohold%0d_grant", i), 32'(grant1), 32'h1);
        end
        req = 4'b0010;
        tick();
        chk("nohold_switch", 32'(grant1), 32'h2);
        tick();
        chk("nohold_out", 32'(out1), 32'h2222);
        chk("nohold_valid", 32'(ov1), 32'h1);

        // Randomized traffic with occasional asynchronous resets.
        do_reset();
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 3) != 0) req = 4'($urandom) | 4'($urandom);
            a = 16'($urandom); b = 16'($urandom);
            c = 16'($urandom); d = 16'($urandom);
            tick();
            if ($urandom_range(0, 79) == 0) begin
                #2;
                reset = 1'b1;
                model_clear();
                #1;
                check_model();
                @(negedge clk);
                reset = 1'b0;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
